branch_redirect_unit: RTL and testbench
=======================================

Name: branch_redirect_unit

Overview:
- Execute-stage producer of the PC redirect interface: resolves conditional branches, JAL and JALR for the instruction in Execute.
- Drives PCSrcE/PCTargetE to the fetch-side next-PC select, plus FlushD/FlushE to squash wrong-path instructions.
- Contains a small state machine that suppresses resolution in the shadow cycle after a redirect and halts redirects after a misaligned target.
- Keeps saturating branch and taken counters.

Parameters:
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ValidE  in  1  Execute stage holds a real (non-bubble) instruction.
- BranchE  in  1  conditional branch.
- JumpE  in  1  JAL.
- JalrE  in  1  JALR (JumpE=0 when JalrE=1).
- Funct3E  in  3  branch condition.
- SrcAE  in  32  rs1 value (forwarded).
- SrcBE  in  32  rs2 value (forwarded).
- PCE  in  32  PC of the Execute instruction.
- ImmExtE  in  32  sign-extended immediate.
- PCSrcE  out  1  take redirect this cycle.
- PCTargetE  out  32  redirect target.
- FlushD  out  1  clear IF/ID next edge.
- FlushE  out  1  clear ID/EX next edge.
- MisalignE  out  1  sticky misaligned-target flag.
- MisalignPC  out  32  PCE of the first faulting instruction.
- BranchCount  out  CNT_W  resolved conditional branches.
- TakenCount  out  CNT_W  redirects issued.

Behaviour:
- States: RUN, SHADOW, HALT. Reset state is RUN.
- Reset values: MisalignE=0, MisalignPC=0, BranchCount=0, TakenCount=0.
- While rst=1, PCSrcE=0, FlushD=0 and FlushE=0, regardless of the other inputs.
- Target computation is combinational and always driven:
  - JALR: PCTargetE = (SrcAE + ImmExtE) with bit 0 cleared.
  - Otherwise: PCTargetE = PCE + ImmExtE.
  - Adders are 32-bit modulo; wrap-around is ignored, e.g. 0xFFFFFFFC + 8 = 0x00000004.
- Condition from Funct3E:
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010 and 011 evaluate not-taken.
- want = ValidE & (JumpE | JalrE | (BranchE & cond)).
- Misaligned target: PCTargetE[1:0] != 0.
- RUN state:
  - If want and the target is aligned: PCSrcE=FlushD=FlushE=1 in the same cycle (zero latency), TakenCount increments, next state SHADOW.
  - If want and the target is misaligned: no redirect (PCSrcE=0, no flushes). Set MisalignE=1 and capture MisalignPC=PCE on the edge. Next state HALT.
  - Otherwise: PCSrcE=0, no flushes, stay in RUN.
  - BranchCount increments for every ValidE&BranchE resolved in RUN, taken or not. This includes a branch that faults on misalignment.
- SHADOW state:
  - Lasts exactly one cycle.
  - PCSrcE, FlushD, FlushE and all counter updates are forced to 0 even if ValidE=1 (defensive; ID/EX should already hold a bubble).
  - Next state RUN.
- HALT state:
  - All outputs quiescent (PCSrcE=0, no flushes, counters frozen).
  - MisalignE and MisalignPC hold their values.
  - Leaves HALT only on rst.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Redirect on back-to-back valid cycles is impossible: the cycle after a redirect is always SHADOW.
- Reset asserted mid-operation (in any state) returns to RUN with all registers cleared on that edge. Outputs are already gated in that same cycle.
- PCTargetE is driven even when PCSrcE=0; consumers use it only when PCSrcE=1.

Test Plan:
- Reset state: hold rst=1 with ValidE=1, JumpE=1 -> PCSrcE=0, flushes 0; after release, counters 0 and MisalignE=0.
- Taken BEQ: PCE=0x100, ImmExtE=0x20, SrcAE=SrcBE=5, Funct3E=000 -> same cycle PCSrcE=1, PCTargetE=0x120, FlushD=FlushE=1. Next cycle, with an identical taken branch presented, PCSrcE=0 (SHADOW). BranchCount=1, TakenCount=1.
- Signed vs unsigned compare: SrcAE=0xFFFFFFFF, SrcBE=1 -> BLT (100) taken, BLTU (110) not taken. Funct3E=010 -> not taken. BranchCount increments on each.
- JALR: SrcAE=0x2001, ImmExtE=0x4 -> PCTargetE=0x2004, PCSrcE=1. JAL with PCE=0x10, ImmExtE=0x6 -> no redirect, MisalignE=1, MisalignPC=0x10. A following valid JAL is ignored until rst.
- Saturation: with CNT_W=4, issue 20 taken branches separated by shadow cycles -> TakenCount and BranchCount stick at 15.
- Mid-operation reset: assert rst in the SHADOW cycle -> next cycle state RUN, counters 0, and a taken branch is honoured immediately after rst deasserts.

Source files
------------

// File: rtl/branch_redirect_unit_if.sv
// Redirect interface between the Execute-stage branch resolver and its consumers.
// Carries the Execute operands in, and the redirect, flush, misalign and counter results out.
interface branch_redirect_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             ValidE;
    logic             BranchE;
    logic             JumpE;
    logic             JalrE;
    logic [2:0]       Funct3E;
    logic [31:0]      SrcAE;
    logic [31:0]      SrcBE;
    logic [31:0]      PCE;
    logic [31:0]      ImmExtE;
    logic             PCSrcE;
    logic [31:0]      PCTargetE;
    logic             FlushD;
    logic             FlushE;
    logic             MisalignE;
    logic [31:0]      MisalignPC;
    logic [CNT_W-1:0] BranchCount;
    logic [CNT_W-1:0] TakenCount;

    modport master (
        output ValidE, BranchE, JumpE, JalrE, Funct3E, SrcAE, SrcBE, PCE, ImmExtE,
        input  PCSrcE, PCTargetE, FlushD, FlushE, MisalignE, MisalignPC,
               BranchCount, TakenCount
    );

    modport slave (
        input  ValidE, BranchE, JumpE, JalrE, Funct3E, SrcAE, SrcBE, PCE, ImmExtE,
        output PCSrcE, PCTargetE, FlushD, FlushE, MisalignE, MisalignPC,
               BranchCount, TakenCount
    );
endinterface

// File: rtl/branch_redirect_unit.sv
// Execute-stage branch/JAL/JALR resolver: zero-latency PC redirect with flushes,
// a one-cycle shadow after each redirect, and a sticky halt on misaligned targets.
module branch_redirect_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_redirect_unit_if.slave bru
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SHADOW = 2'd1,
        ST_HALT   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;
    logic             misalign_q, misalign_d;
    logic [31:0]      misalign_pc_q, misalign_pc_d;

    logic [31:0]      target_sum;
    logic [31:0]      target;
    logic             cond;
    logic             want;
    logic             tgt_misaligned;
    logic             redirect;
    logic             branch_inc;
    logic             taken_inc;
    logic             misalign_set;

    // JALR adds to rs1 and drops bit 0; everything else is PC-relative.
    always_comb begin
        target_sum = (bru.JalrE ? bru.SrcAE : bru.PCE) + bru.ImmExtE;
        target     = bru.JalrE ? {target_sum[31:1], 1'b0} : target_sum;
    end

    always_comb begin
        cond = 1'b0;
        case (bru.Funct3E)
            3'b000:  cond = (bru.SrcAE == bru.SrcBE);
            3'b001:  cond = (bru.SrcAE != bru.SrcBE);
            3'b100:  cond = ($signed(bru.SrcAE) <  $signed(bru.SrcBE));
            3'b101:  cond = ($signed(bru.SrcAE) >= $signed(bru.SrcBE));
            3'b110:  cond = (bru.SrcAE <  bru.SrcBE);
            3'b111:  cond = (bru.SrcAE >= bru.SrcBE);
            default: cond = 1'b0;
        endcase
    end

    assign want           = bru.ValidE & (bru.JumpE | bru.JalrE | (bru.BranchE & cond));
    assign tgt_misaligned = |target[1:0];

    // Next-state logic; reset is applied in the state register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (want) state_d = tgt_misaligned ? ST_HALT : ST_SHADOW;
            ST_SHADOW: state_d = ST_RUN;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_RUN;
        endcase
    end

    // Only RUN may redirect or count; reset gates everything in its own cycle.
    always_comb begin
        redirect     = 1'b0;
        taken_inc    = 1'b0;
        branch_inc   = 1'b0;
        misalign_set = 1'b0;
        if (!rst && state_q == ST_RUN) begin
            redirect     = want & ~tgt_misaligned;
            taken_inc    = want & ~tgt_misaligned;
            branch_inc   = bru.ValidE & bru.BranchE;
            misalign_set = want & tgt_misaligned;
        end
    end

    always_comb begin
        branch_count_d = branch_count_q;
        taken_count_d  = taken_count_q;
        if (branch_inc && branch_count_q != CNT_MAX) branch_count_d = branch_count_q + CNT_W'(1);
        if (taken_inc && taken_count_q != CNT_MAX)   taken_count_d  = taken_count_q + CNT_W'(1);
        misalign_d    = misalign_q | misalign_set;
        misalign_pc_d = misalign_set ? bru.PCE : misalign_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            branch_count_q <= '0;
            taken_count_q  <= '0;
            misalign_q     <= 1'b0;
            misalign_pc_q  <= '0;
        end else begin
            state_q        <= state_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
            misalign_q     <= misalign_d;
            misalign_pc_q  <= misalign_pc_d;
        end
    end

    assign bru.PCSrcE      = redirect;
    assign bru.FlushD      = redirect;
    assign bru.FlushE      = redirect;
    assign bru.PCTargetE   = target;
    assign bru.MisalignE   = misalign_q;
    assign bru.MisalignPC  = misalign_pc_q;
    assign bru.BranchCount = branch_count_q;
    assign bru.TakenCount  = taken_count_q;
endmodule

// File: tb/tb_branch_redirect_unit.sv
// Bench for branch_redirect_unit: directed scenarios then random traffic, all
// checked against a cycle-level behavioural model held in this module.
module tb_branch_redirect_unit;
    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    branch_redirect_unit_if #(.CNT_W(CNT_W)) ifc ();

    branch_redirect_unit #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bru (ifc)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    bit          m_shadow;
    bit          m_halt;
    bit          m_mis;
    logic [31:0] m_mispc;
    int          m_branch;
    int          m_taken;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: drive at negedge, check combinational outputs, step model at posedge, check state.
    task automatic cycle(input bit r, input bit v, input bit br, input bit j, input bit jr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm);
        logic [31:0] tgt;
        bit          wants;
        bit          aligned;
        bit          active;
        bit          exp_redir;
        @(negedge clk);
        rst         = r;
        ifc.ValidE  = v;
        ifc.BranchE = br;
        ifc.JumpE   = j;
        ifc.JalrE   = jr;
        ifc.Funct3E = f3;
        ifc.SrcAE   = a;
        ifc.SrcBE   = b;
        ifc.PCE     = pc;
        ifc.ImmExtE = imm;
        #1;
        tgt       = jr ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
        wants     = v && (j || jr || (br && ref_cond(f3, a, b)));
        aligned   = (tgt % 4) == 0;
        active    = !r && !m_shadow && !m_halt;
        exp_redir = active && wants && aligned;
        check("PCSrcE",    32'(ifc.PCSrcE),    32'(exp_redir));
        check("FlushD",    32'(ifc.FlushD),    32'(exp_redir));
        check("FlushE",    32'(ifc.FlushE),    32'(exp_redir));
        check("PCTargetE", ifc.PCTargetE,      tgt);
        @(posedge clk);
        if (r) begin
            m_shadow = 0; m_halt = 0; m_mis = 0; m_mispc = '0; m_branch = 0; m_taken = 0;
        end else if (m_shadow) begin
            m_shadow = 0;
        end else if (!m_halt) begin
            if (v && br) m_branch = (m_branch < CMAX) ? m_branch + 1 : CMAX;
            if (wants && aligned) begin
                m_taken  = (m_taken < CMAX) ? m_taken + 1 : CMAX;
                m_shadow = 1;
            end else if (wants) begin
                m_halt  = 1;
                m_mis   = 1;
                m_mispc = pc;
            end
        end
        #1;
        check("BranchCount", 32'(ifc.BranchCount), 32'(m_branch));
        check("TakenCount",  32'(ifc.TakenCount),  32'(m_taken));
        check("MisalignE",   32'(ifc.MisalignE),   32'(m_mis));
        check("MisalignPC",  ifc.MisalignPC,       m_mispc);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] ra, rb, rimm;
        int          kind;
        m_shadow = 0; m_halt = 0; m_mis = 0; m_mispc = '0; m_branch = 0; m_taken = 0;

        // Reset held with a valid JAL presented: no redirect, state cleared.
        cycle(1, 1, 0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h40, 32'h8);
        cycle(1, 1, 0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h40, 32'h8);

        // Taken BEQ, then identical branch in the shadow cycle.
        cycle(0, 1, 1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
        cycle(0, 1, 1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20);

        // Signed vs unsigned less-than, and a reserved funct3.
        cycle(0, 1, 1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        idle();
        cycle(0, 1, 1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h204, 32'h40);
        cycle(0, 1, 1, 0, 0, 3'b010, 32'd3, 32'd3, 32'h208, 32'h40);

        // JALR clears bit 0; wrap-around PC-relative target.
        cycle(0, 1, 0, 0, 1, 3'b000, 32'h2001, 32'h0, 32'h300, 32'h4);
        idle();
        cycle(0, 1, 1, 0, 0, 3'b001, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h8);
        idle();

        // Misaligned JAL halts; later jumps ignored until reset.
        cycle(0, 1, 0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h10, 32'h6);
        cycle(0, 1, 0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h20, 32'h8);
        cycle(0, 1, 1, 0, 0, 3'b000, 32'h1, 32'h1, 32'h24, 32'h8);

        // Saturation: 20 taken branches, each followed by its shadow cycle.
        cycle(1, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 40; i++)
            cycle(0, 1, 1, 0, 0, 3'b000, 32'h7, 32'h7, 32'h400 + 32'(i * 4), 32'h10);

        // Reset in the shadow cycle, then a taken branch honoured at once.
        cycle(1, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
        cycle(0, 1, 0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h500, 32'h20);
        cycle(1, 1, 0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h520, 32'h20);
        cycle(0, 1, 1, 0, 0, 3'b101, 32'd9, 32'd2, 32'h600, 32'h80);

        // Random traffic with sporadic resets.
        for (int i = 0; i < 400; i++) begin
            ra   = $urandom;
            rb   = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rimm = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            kind = $urandom_range(0, 5);
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0,
                  kind <= 2, kind == 3, kind == 4, 3'($urandom_range(0, 7)),
                  ra, rb, $urandom & 32'hFFFF_FFFC, rimm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
